pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Game-level sequencer for the Pong ball/paddle datapath. It evaluates ball position against the paddles once per video frame and decides the outcome: hit (bounce), miss (point), serve or game over. It drives the ball datapath's run/recentre/bounce controls and keeps both players' scores. It sits between the VGA frame timing and the ball and paddle position registers.

Parameters:
MAX_X, 640, horizontal playfield size in pixels
MAX_Y, 480, vertical playfield size in pixels
BALL_SIZE, 16, ball edge length in pixels
PADDLE_H, 64, paddle height in pixels
PADDLE_L_X, 16, right edge x of left paddle (ball left-edge contact column)
PADDLE_R_X, 608, left edge x of right paddle (ball right-edge contact column)
SERVE_FRAMES, 60, frames held in SERVE before play resumes
WIN_SCORE, 9, score that ends the game (max 15)

Ports:
clk  in  1  system pixel clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame, start of vertical blank
start_btn  in  1  debounced start request, level
ball_x  in  10  ball top-left x, unsigned
ball_y  in  10  ball top-left y, unsigned
paddle_l_y  in  10  left paddle top y
paddle_r_y  in  10  right paddle top y
ball_run  out  1  high = ball datapath may advance position
ball_recentre  out  1  one-cycle pulse: load ball to (MAX_X/2, MAX_Y/2)
bounce_l  out  1  one-cycle pulse: force x velocity to +1 (left paddle hit)
bounce_r  out  1  one-cycle pulse: force x velocity to -1 (right paddle hit)
serve_dir  out  1  0 = serve toward left, 1 = toward right
score_l  out  4  left player score
score_r  out  4  right player score
game_over  out  1  high while in OVER
state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- Reset (async, rst_n low): state=IDLE, scores=0, ball_run=0, all pulses 0, serve_dir=1, serve counter=0, game_over=0.
- All decisions are registered and happen only in a cycle with frame_tick=1, except the IDLE start check. Outputs change 1 clk after the deciding edge.
- IDLE: ball_run=0. start_btn=1 -> SERVE, scores cleared, ball_recentre pulsed.
- SERVE: ball_run=0. Counter increments per frame_tick. The tick bringing the count to SERVE_FRAMES -> PLAY, counter cleared.
- PLAY: ball_run=1. Tests run on each frame_tick, in priority order, all arithmetic 11-bit unsigned (no wrap):
  - Vertical overlap with a paddle means (ball_y+BALL_SIZE > pad_y) and (ball_y < pad_y+PADDLE_H).
  - Left contact, ball_x <= PADDLE_L_X: overlap with left paddle -> bounce_l pulse; otherwise right scores, serve_dir=0 (toward the loser, left), -> POINT.
  - Right contact, ball_x+BALL_SIZE >= PADDLE_R_X: overlap with right paddle -> bounce_r pulse; otherwise left scores, serve_dir=1, -> POINT.
  - Both contacts in one tick is impossible for legal parameters. If it occurs, the left test wins.
- Edge overlap counts as a hit, e.g. ball_y+BALL_SIZE == pad_y+1.
- POINT: ball_run=0. If the incremented score == WIN_SCORE -> OVER. Otherwise ball_recentre pulse -> SERVE. One clk in POINT.
- OVER: game_over=1, ball_run=0, scores held. start_btn=1 -> SERVE with scores cleared and ball_recentre pulsed.
- start_btn is ignored in SERVE, PLAY and POINT.
- Scores never exceed WIN_SCORE.
- Reset mid-game returns to the IDLE state regardless of any pending pulse.

Optional Feature:
- Macro: PONG_ATTRACT_EN.
- Defined: IDLE drives ball_run=1, and bounce_l/bounce_r pulse on every left/right contact regardless of paddle overlap (demo mode, no scoring). On leaving IDLE via start_btn, ball_recentre is pulsed as normal.
- Undefined: IDLE holds ball_run=0 and issues no bounces.

Test Plan:
- Reset with start_btn=1: state=0, scores=0, serve_dir=1. Release rst_n; next clk: state=1 and one ball_recentre pulse.
- SERVE timing: count frame_ticks. ball_run rises 1 clk after the 60th tick, with state=2.
- Left hit: PLAY, ball_x=16, ball_y=200, paddle_l_y=150, tick -> single bounce_l pulse, state stays 2, scores unchanged.
- Left miss: ball_x=10, ball_y=300, paddle_l_y=100, tick -> score_r 0->1, serve_dir=0, POINT for 1 clk, then SERVE with ball_recentre pulse.
- Edge overlap: ball_y=85, paddle_r_y=100, ball_x=592 (85+16=101 > 100) -> bounce_r. With ball_y=84 (84+16=100) -> score_l increments.
- Win and restart: score_l=8 plus a right miss -> score_l=9, state=4, game_over=1. start_btn -> SERVE with scores 0. Assert rst_n mid-PLAY -> IDLE immediately.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game-level sequencer: per-frame paddle/ball contact evaluation, scoring,
// serve timing and game-over handling.
// Optional feature macro: PONG_ATTRACT_EN (demo mode, ball runs and bounces in IDLE).
module pong_game_ctrl #(
  parameter int unsigned MAX_X        = 640,
  parameter int unsigned MAX_Y        = 480,
  parameter int unsigned BALL_SIZE    = 16,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned PADDLE_L_X   = 16,
  parameter int unsigned PADDLE_R_X   = 608,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_start_btn,
  input  logic [9:0] i_ball_x,
  input  logic [9:0] i_ball_y,
  input  logic [9:0] i_paddle_l_y,
  input  logic [9:0] i_paddle_r_y,
  output logic       o_ball_run,
  output logic       o_ball_recentre,
  output logic       o_bounce_l,
  output logic       o_bounce_r,
  output logic       o_serve_dir,
  output logic [3:0] o_score_l,
  output logic [3:0] o_score_r,
  output logic       o_game_over,
  output logic [2:0] o_state
);

  // Reject geometries where both contact columns could be hit in one frame.
  if (PADDLE_L_X + BALL_SIZE >= PADDLE_R_X || PADDLE_R_X > MAX_X || PADDLE_H > MAX_Y ||
      WIN_SCORE > 15 || WIN_SCORE == 0 || SERVE_FRAMES == 0) begin : g_bad_params
    $error("pong_game_ctrl: illegal parameter combination");
  end

  localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SERVE_FRAMES - 1);
  localparam logic [10:0] BallSz  = 11'(BALL_SIZE);
  localparam logic [10:0] PadH    = 11'(PADDLE_H);
  localparam logic [10:0] PadLX   = 11'(PADDLE_L_X);
  localparam logic [10:0] PadRX   = 11'(PADDLE_R_X);
  localparam logic [3:0]  WinScr  = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_serve_cnt, w_serve_cnt_d;
  logic [3:0]      r_score_l, w_score_l_d, r_score_r, w_score_r_d;
  logic            r_serve_dir, w_serve_dir_d;
  logic            r_recentre, w_recentre_d;
  logic            r_bounce_l, w_bounce_l_d, r_bounce_r, w_bounce_r_d;

  // 11-bit geometry so sums of 10-bit coordinates never wrap.
  logic [10:0] w_bx, w_by, w_pl, w_pr;
  logic        w_contact_l, w_contact_r, w_ovl_l, w_ovl_r;

  // Contact and vertical-overlap tests against both paddles.
  always_comb begin
    w_bx        = {1'b0, i_ball_x};
    w_by        = {1'b0, i_ball_y};
    w_pl        = {1'b0, i_paddle_l_y};
    w_pr        = {1'b0, i_paddle_r_y};
    w_contact_l = (w_bx <= PadLX);
    w_contact_r = (w_bx + BallSz >= PadRX);
    w_ovl_l     = (w_by + BallSz > w_pl) && (w_by < w_pl + PadH);
    w_ovl_r     = (w_by + BallSz > w_pr) && (w_by < w_pr + PadH);
  end

  // State, counter, scores and output pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_serve_cnt <= '0;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_serve_dir <= 1'b1;
      r_recentre  <= 1'b0;
      r_bounce_l  <= 1'b0;
      r_bounce_r  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_serve_cnt <= w_serve_cnt_d;
      r_score_l   <= w_score_l_d;
      r_score_r   <= w_score_r_d;
      r_serve_dir <= w_serve_dir_d;
      r_recentre  <= w_recentre_d;
      r_bounce_l  <= w_bounce_l_d;
      r_bounce_r  <= w_bounce_r_d;
    end
  end

  // Next-state and next-pulse decisions; pulses default low every cycle.
  always_comb begin
    w_state_d     = r_state;
    w_serve_cnt_d = r_serve_cnt;
    w_score_l_d   = r_score_l;
    w_score_r_d   = r_score_r;
    w_serve_dir_d = r_serve_dir;
    w_recentre_d  = 1'b0;
    w_bounce_l_d  = 1'b0;
    w_bounce_r_d  = 1'b0;
    case (r_state)
      StIdle: begin
`ifdef PONG_ATTRACT_EN
        if (i_frame_tick) begin
          if (w_contact_l) begin
            w_bounce_l_d = 1'b1;
          end else if (w_contact_r) begin
            w_bounce_r_d = 1'b1;
          end
        end
`endif
        if (i_start_btn) begin
          w_state_d    = StServe;
          w_score_l_d  = '0;
          w_score_r_d  = '0;
          w_recentre_d = 1'b1;
          w_bounce_l_d = 1'b0;
          w_bounce_r_d = 1'b0;
        end
      end
      StServe: begin
        if (i_frame_tick) begin
          if (r_serve_cnt == CntLast) begin
            w_state_d     = StPlay;
            w_serve_cnt_d = '0;
          end else begin
            w_serve_cnt_d = r_serve_cnt + 1'b1;
          end
        end
      end
      StPlay: begin
        if (i_frame_tick) begin
          // Left test has priority if both contacts ever coincide.
          if (w_contact_l) begin
            if (w_ovl_l) begin
              w_bounce_l_d = 1'b1;
            end else begin
              w_score_r_d   = (r_score_r < WinScr) ? r_score_r + 4'd1 : r_score_r;
              w_serve_dir_d = 1'b0;
              w_state_d     = StPoint;
            end
          end else if (w_contact_r) begin
            if (w_ovl_r) begin
              w_bounce_r_d = 1'b1;
            end else begin
              w_score_l_d   = (r_score_l < WinScr) ? r_score_l + 4'd1 : r_score_l;
              w_serve_dir_d = 1'b1;
              w_state_d     = StPoint;
            end
          end
        end
      end
      StPoint: begin
        if (r_score_l == WinScr || r_score_r == WinScr) begin
          w_state_d = StOver;
        end else begin
          w_state_d    = StServe;
          w_recentre_d = 1'b1;
        end
      end
      StOver: begin
        if (i_frame_tick && i_start_btn) begin
          w_state_d    = StServe;
          w_score_l_d  = '0;
          w_score_r_d  = '0;
          w_recentre_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Level outputs decoded from the registered state.
  always_comb begin
`ifdef PONG_ATTRACT_EN
    o_ball_run = (r_state == StPlay) || (r_state == StIdle);
`else
    o_ball_run = (r_state == StPlay);
`endif
    o_game_over     = (r_state == StOver);
    o_state         = r_state;
    o_ball_recentre = r_recentre;
    o_bounce_l      = r_bounce_l;
    o_bounce_r      = r_bounce_r;
    o_serve_dir     = r_serve_dir;
    o_score_l       = r_score_l;
    o_score_r       = r_score_r;
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl (default build, attract mode off).
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       start_btn;
  logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic       ball_run, ball_recentre, bounce_l, bounce_r, serve_dir, game_over;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  pong_game_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_frame_tick   (frame_tick),
    .i_start_btn    (start_btn),
    .i_ball_x       (ball_x),
    .i_ball_y       (ball_y),
    .i_paddle_l_y   (paddle_l_y),
    .i_paddle_r_y   (paddle_r_y),
    .o_ball_run     (ball_run),
    .o_ball_recentre(ball_recentre),
    .o_bounce_l     (bounce_l),
    .o_bounce_r     (bounce_r),
    .o_serve_dir    (serve_dir),
    .o_score_l      (score_l),
    .o_score_r      (score_r),
    .o_game_over    (game_over),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with frame_tick high; returns 1 time unit after the edge.
  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // From SERVE, 60 spaced ticks with the ball parked mid-field.
  task automatic serve_to_play();
    ball_x = 10'd300;
    ball_y = 10'd200;
    for (int i = 0; i < 60; i++) begin
      tick();
      idle();
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    start_btn  = 1'b1;
    ball_x     = 10'd300;
    ball_y     = 10'd200;
    paddle_l_y = 10'd150;
    paddle_r_y = 10'd100;

    // Reset state with start held
    #23;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_score_l", 16'(score_l), 16'd0);
    chk("rst_score_r", 16'(score_r), 16'd0);
    chk("rst_serve_dir", 16'(serve_dir), 16'd1);
    chk("rst_ball_run", 16'(ball_run), 16'd0);
    chk("rst_game_over", 16'(game_over), 16'd0);
    chk("rst_recentre", 16'(ball_recentre), 16'd0);
    #7;
    rst_n = 1'b1;
    idle();
    chk("start_state", 16'(state), 16'd1);
    chk("start_recentre", 16'(ball_recentre), 16'd1);
    start_btn = 1'b0;
    idle();
    chk("start_recentre_pulse", 16'(ball_recentre), 16'd0);
    chk("serve_ball_run", 16'(ball_run), 16'd0);

    // Serve timing: 59 ticks keep SERVE, 60th moves to PLAY
    for (int i = 0; i < 59; i++) begin
      tick();
      idle();
    end
    chk("serve59_state", 16'(state), 16'd1);
    chk("serve59_ball_run", 16'(ball_run), 16'd0);
    tick();
    chk("serve60_state", 16'(state), 16'd2);
    chk("serve60_ball_run", 16'(ball_run), 16'd1);
    idle();

    // start_btn ignored in PLAY
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    chk("play_start_ignored", 16'(state), 16'd2);

    // Left hit: 216 > 150 and 200 < 214
    ball_x = 10'd16; ball_y = 10'd200; paddle_l_y = 10'd150;
    tick();
    ball_x = 10'd300;
    chk("lhit_bounce_l", 16'(bounce_l), 16'd1);
    chk("lhit_bounce_r", 16'(bounce_r), 16'd0);
    chk("lhit_state", 16'(state), 16'd2);
    chk("lhit_scores", {8'd0, score_l, score_r}, 16'h0000);
    idle();
    chk("lhit_pulse_end", 16'(bounce_l), 16'd0);

    // Left bottom-edge hit: 163 < 100+64
    ball_x = 10'd0; ball_y = 10'd163; paddle_l_y = 10'd100;
    tick();
    ball_x = 10'd300;
    chk("lbot_bounce_l", 16'(bounce_l), 16'd1);
    chk("lbot_state", 16'(state), 16'd2);
    idle();

    // Left miss: 300 >= 164
    ball_x = 10'd10; ball_y = 10'd300; paddle_l_y = 10'd100;
    tick();
    chk("lmiss_state", 16'(state), 16'd3);
    chk("lmiss_score_r", 16'(score_r), 16'd1);
    chk("lmiss_score_l", 16'(score_l), 16'd0);
    chk("lmiss_serve_dir", 16'(serve_dir), 16'd0);
    chk("lmiss_ball_run", 16'(ball_run), 16'd0);
    chk("lmiss_bounce_l", 16'(bounce_l), 16'd0);
    idle();
    chk("lmiss_serve_state", 16'(state), 16'd1);
    chk("lmiss_recentre", 16'(ball_recentre), 16'd1);
    idle();
    chk("lmiss_recentre_end", 16'(ball_recentre), 16'd0);

    serve_to_play();
    chk("play2_state", 16'(state), 16'd2);

    // Right edge hit: 85+16=101 > 100
    ball_x = 10'd592; ball_y = 10'd85; paddle_r_y = 10'd100;
    tick();
    ball_x = 10'd300;
    chk("redge_bounce_r", 16'(bounce_r), 16'd1);
    chk("redge_state", 16'(state), 16'd2);
    idle();
    chk("redge_pulse_end", 16'(bounce_r), 16'd0);

    // Right edge miss: 84+16=100 not > 100
    ball_x = 10'd592; ball_y = 10'd84;
    tick();
    chk("rmiss_state", 16'(state), 16'd3);
    chk("rmiss_score_l", 16'(score_l), 16'd1);
    chk("rmiss_serve_dir", 16'(serve_dir), 16'd1);
    chk("rmiss_bounce_r", 16'(bounce_r), 16'd0);
    idle();
    chk("rmiss_serve_state", 16'(state), 16'd1);

    // Drive score_l up to 9 with right misses
    for (int i = 0; i < 8; i++) begin
      serve_to_play();
      ball_x = 10'd592; ball_y = 10'd84; paddle_r_y = 10'd100;
      tick();
      ball_x = 10'd300;
      chk("win_point_state", 16'(state), 16'd3);
      chk("win_score_l", 16'(score_l), 16'(2 + i));
      idle();
    end
    chk("over_state", 16'(state), 16'd4);
    chk("over_game_over", 16'(game_over), 16'd1);
    chk("over_recentre", 16'(ball_recentre), 16'd0);
    chk("over_scores", {8'd0, score_l, score_r}, 16'h0091);
    tick();
    chk("over_hold_state", 16'(state), 16'd4);
    chk("over_ball_run", 16'(ball_run), 16'd0);

    // Restart from OVER
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    chk("restart_state", 16'(state), 16'd1);
    chk("restart_scores", {8'd0, score_l, score_r}, 16'h0000);
    chk("restart_recentre", 16'(ball_recentre), 16'd1);
    chk("restart_game_over", 16'(game_over), 16'd0);
    idle();

    // Async reset mid-PLAY with a bounce pending
    serve_to_play();
    chk("prereset_state", 16'(state), 16'd2);
    ball_x = 10'd16; ball_y = 10'd200; paddle_l_y = 10'd150;
    frame_tick = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 16'(state), 16'd0);
    chk("midrst_ball_run", 16'(ball_run), 16'd0);
    frame_tick = 1'b0;
    idle();
    chk("midrst_bounce_l", 16'(bounce_l), 16'd0);
    chk("midrst_serve_dir", 16'(serve_dir), 16'd1);
    chk("midrst_state_hold", 16'(state), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
